// File: rtl/muldiv_unit_if.sv
// Handshake and data bundle between the pipeline and the iterative multiply/divide unit.
interface muldiv_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        hilo_we;

    modport master (
        output start, op, src_a, src_b, flush,
        input  busy, done, result, hilo_we
    );

    modport slave (
        input  start, op, src_a, src_b, flush,
        output busy, done, result, hilo_we
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit producing {hi, lo} for the HILO register.
// Fixed 32-iteration latency for every operation; flush aborts, rst clears the result.
//
// state | meaning
// IDLE  | waiting for start; operands latched on acceptance
// MUL   | radix-2 shift-add, one multiplier bit per cycle
// DIV   | radix-2 restoring division, one quotient bit per cycle
// DONE  | result registered; done/hilo_we pulse for one cycle
module muldiv_unit (
    input  logic           clk,
    input  logic           rst,
    muldiv_unit_if.slave   bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [31:0] opnd;
    logic        sign_res;
    logic        sign_rem;
    logic        div_zero;
    logic [63:0] result_q;

    logic        signed_op;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_trial;
    logic [63:0] div_next;
    logic [63:0] mul_final;
    logic [31:0] div_lo;
    logic [31:0] div_hi;

    assign signed_op = ~bus.op[0];
    assign a_neg     = signed_op & bus.src_a[31];
    assign b_neg     = signed_op & bus.src_b[31];
    assign mag_a     = a_neg ? (32'd0 - bus.src_a) : bus.src_a;
    assign mag_b     = b_neg ? (32'd0 - bus.src_b) : bus.src_b;

    // Multiply: acc = {partial product high, remaining multiplier bits}.
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    assign mul_next = {mul_sum, acc[31:1]};

    // Divide: acc = {remainder, dividend bits being shifted out / quotient shifted in}.
    // Remainder stays below the divisor, so bit 32 of the trial is a clean borrow flag.
    assign div_trial = {acc[63:32], acc[31]} - {1'b0, opnd};
    assign div_next  = div_trial[32] ? {acc[62:0], 1'b0}
                                     : {div_trial[31:0], acc[30:0], 1'b1};

    assign mul_final = sign_res ? (64'd0 - mul_next) : mul_next;
    assign div_lo    = div_zero ? 32'hFFFF_FFFF
                     : (sign_res ? (32'd0 - div_next[31:0]) : div_next[31:0]);
    assign div_hi    = sign_rem ? (32'd0 - div_next[63:32]) : div_next[63:32];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            acc      <= 64'd0;
            opnd     <= 32'd0;
            sign_res <= 1'b0;
            sign_rem <= 1'b0;
            div_zero <= 1'b0;
            result_q <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        cnt      <= 5'd0;
                        sign_res <= a_neg ^ b_neg;
                        sign_rem <= a_neg;
                        div_zero <= (bus.src_b == 32'd0);
                        if (bus.op[1]) begin
                            acc   <= {32'd0, mag_a};
                            opnd  <= mag_b;
                            state <= DIV;
                        end else begin
                            acc   <= {32'd0, mag_b};
                            opnd  <= mag_a;
                            state <= MUL;
                        end
                    end
                end
                MUL, DIV: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        acc <= (state == MUL) ? mul_next : div_next;
                        if (cnt == 5'd31) begin
                            state    <= DONE;
                            result_q <= (state == MUL) ? mul_final : {div_hi, div_lo};
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = (state == MUL) || (state == DIV);
    assign bus.done    = (state == DONE) && !bus.flush;
    assign bus.hilo_we = bus.done;
    assign bus.result  = result_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-004 SHALL have port op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have port src_a  input  32  multiplicand / dividend.
REQ-006 SHALL have port src_b  input  32  multiplier / divisor.
REQ-007 SHALL have port flush  input  1  pipeline exception or flush; aborts any operation.
REQ-008 SHALL have port busy  output  1  high while an operation is iterating; the pipeline uses it to stall.
REQ-009 SHALL have port done  output  1  one-cycle pulse; result is valid.
REQ-010 SHALL have port result  output  64  {hi, lo}; feeds the HILO register write data.
REQ-011 SHALL have port hilo_we  output  1  HILO write enable; equal to done.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV, DONE, with a 5-bit iteration counter.
REQ-013 IDLE: if start=1 and flush=0 at edge E0, SHALL latch op and the operand magnitudes, clear the counter, and enter MUL (op[1]=0) or DIV (op[1]=1).
REQ-014 Signed ops (MULT, DIV) SHALL convert negative operands to their two's-complement magnitude and record the result sign(s); unsigned ops SHALL use operands as-is.
REQ-015 MUL SHALL perform radix-2 shift-add, one bit per cycle, for 32 iterations at edges E1..E32.
REQ-016 DIV SHALL perform radix-2 restoring division, one quotient bit per cycle, for 32 iterations at edges E1..E32.
REQ-017 After E32 the state SHALL be DONE; done=1 and hilo_we=1 for exactly that cycle; next edge returns to IDLE.
REQ-018 Latency SHALL be fixed: done is high in the cycle after E32, independent of operand values.
REQ-019 busy SHALL be 1 exactly when the state is MUL or DIV; 0 in IDLE and DONE.
REQ-020 MULT result SHALL be the 64-bit two's-complement product, negated when operand signs differ; MULTU SHALL give the unsigned 64-bit product.
REQ-021 DIV SHALL give lo=quotient, negated when signs differ; hi=remainder, carrying the dividend's sign. DIVU SHALL give the unsigned quotient and remainder.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000, with no error indication.
REQ-023 Divide by zero (any DIV/DIVU) SHALL still take 32 cycles and assert done/hilo_we, with lo=0xFFFFFFFF and hi=src_a as latched.
REQ-024 result SHALL be registered, update only on entry to DONE, and hold its value until the next DONE.
REQ-025 start asserted outside IDLE SHALL be ignored; operand and op changes after E0 SHALL have no effect.
REQ-026 flush=1 in MUL, DIV or DONE SHALL return the state to IDLE at the next edge, with done/hilo_we forced 0 in the flush cycle and result unchanged.
REQ-027 start and flush both 1 in IDLE SHALL leave the state in IDLE.
REQ-028 The counter SHALL not wrap: exit on count 31 occurs before any wrap to 0.

Reset
REQ-029 rst=1 at any edge SHALL set the state to IDLE, the counter to 0, and result to 64'h0; busy, done and hilo_we SHALL be 0.
REQ-030 rst SHALL take priority over flush and start, including mid-operation; no done pulse SHALL follow.

Verification
REQ-031 MULT src_a=0xFFFFFFFE (-2), src_b=0x00000003 -> done in the cycle after E32; result=0xFFFFFFFF_FFFFFFFA; busy high for 32 cycles.
REQ-032 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE_00000001; hilo_we is a single-cycle pulse.
REQ-033 DIV -7 / 2 (0xFFFFFFF9, 0x00000002) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=0x0000000E, hi=0x00000002.
REQ-034 DIVU 0x12345678 / 0 -> after 32 cycles lo=0xFFFFFFFF, hi=0x12345678; signed 0x80000000 / -1 -> lo=0x80000000, hi=0.
REQ-035 Start DIV, assert flush at iteration 10 -> IDLE next edge, no done, result unchanged; assert start during busy -> ignored; start+flush in IDLE -> stays IDLE.
REQ-036 Assert rst at iteration 20 of MULT -> next cycle busy=0, done=0, result=0; a new start afterwards completes normally.
